// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and cell idle level for the serial add sequencer
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic CELL_IDLE_LVL = 1'b1;

endpackage

// File: rtl/serial_shift_reg.sv
// rtl/serial_shift_reg.sv - parallel-load, shift-right register with serial input at the MSB
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial add sequencer driving an external active-low full-adder cell
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             adder_a_n,
    output logic             adder_b_n,
    output logic             adder_cin_n,
    input  logic             adder_s,
    input  logic             adder_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic             load;
    logic             shift;
    logic             last;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             unused;

    assign load  = (state == IDLE) && start;
    assign shift = (state == RUN);
    assign last  = shift && (cnt == CW'(WIDTH - 1));

    serial_shift_reg #(.WIDTH(WIDTH)) u_a_sh (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (a),
        .shift     (shift),
        .sin       (1'b0),
        .q         (a_q)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_b_sh (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (b),
        .shift     (shift),
        .sin       (1'b0),
        .q         (b_q)
    );

    // Result enters at the MSB so after WIDTH shifts the first sum bit sits at bit 0.
    serial_shift_reg #(.WIDTH(WIDTH)) u_res_sh (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data ('0),
        .shift     (shift),
        .sin       (adder_s),
        .q         (res_q)
    );

    assign unused = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1], res_q[0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        adder_a_n   = CELL_IDLE_LVL;
        adder_b_n   = CELL_IDLE_LVL;
        adder_cin_n = CELL_IDLE_LVL;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy        = 1'b1;
                adder_a_n   = ~a_q[0];
                adder_b_n   = ~b_q[0];
                adder_cin_n = ~carry;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // sum/cout are cleared on accept and written only on the final bit edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (shift) begin
            carry <= adder_cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= {adder_s, res_q[WIDTH-1:1]};
                cout <= adder_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - self-checking bench for serial_add_seq with an active-low full-adder cell
module tb_serial_add_seq;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] s;
        logic             co;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             adder_a_n;
    logic             adder_b_n;
    logic             adder_cin_n;
    logic             adder_s;
    logic             adder_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_count = 0;
    int   done_cyc[$];
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .adder_a_n   (adder_a_n),
        .adder_b_n   (adder_b_n),
        .adder_cin_n (adder_cin_n),
        .adder_s     (adder_s),
        .adder_cout  (adder_cout),
        .busy        (busy),
        .done        (done),
        .sum         (sum),
        .cout        (cout)
    );

    // Full-adder cell: active-low inputs, active-high outputs.
    logic ca, cb, cc;
    assign ca         = ~adder_a_n;
    assign cb         = ~adder_b_n;
    assign cc         = ~adder_cin_n;
    assign adder_s    = ca ^ cb ^ cc;
    assign adder_cout = (ca & cb) | (ca & cc) | (cb & cc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && (!busy || done)) begin
            check("idle_cell_inputs", {29'd0, adder_a_n, adder_b_n, adder_cin_n}, 32'h7);
        end
        if (rst_n && done) begin
            done_count++;
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_sum", 32'(sum), 32'(mon_e.s));
                check("sb_cout", 32'(cout), 32'(mon_e.co));
            end
        end
    end

    task automatic do_start(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                            input logic vc, input logic [WIDTH-1:0] es, input logic eco);
        exp_t e;
        @(posedge clk);
        #1;
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        e.s   = es;
        e.co  = eco;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        for (int i = 1; i <= 3 * WIDTH; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (i == 1) check("sum_zero_while_busy", 32'(sum), 32'd0);
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat, bn;
        do_start(v.a, v.b, v.cin, v.s, v.co);
        wait_done(lat, bn);
        check("latency", 32'(lat), 32'(WIDTH + 1));
        check("busy_cycles", 32'(bn), 32'(WIDTH + 1));
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int lat, bn, dc0, n0;
        logic [WIDTH:0] m;
        vec_t rv;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};

        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h44;
        cin   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_cell_inputs", {29'd0, adder_a_n, adder_b_n, adder_cin_n}, 32'h7);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            rv.a   = WIDTH'($urandom);
            rv.b   = WIDTH'($urandom);
            rv.cin = 1'($urandom);
            m      = {1'b0, rv.a} + {1'b0, rv.b} + {{WIDTH{1'b0}}, rv.cin};
            rv.s   = m[WIDTH-1:0];
            rv.co  = m[WIDTH];
            run_vec(rv);
        end

        // start pulsed mid-RUN must be ignored
        dc0 = done_count;
        do_start(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bn);
        repeat (WIDTH + 4) @(negedge clk);
        check("ignored_start_one_done", 32'(done_count - dc0), 32'd1);

        // reset mid-RUN discards the add
        do_start(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        dc0 = done_count;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        repeat (WIDTH + 3) @(negedge clk);
        check("midrst_no_done", 32'(done_count), 32'(dc0));
        run_vec('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});

        // start held high: back-to-back adds
        n0 = done_cyc.size();
        @(posedge clk);
        #1;
        a     = 8'h11;
        b     = 8'h22;
        cin   = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back('{8'h34, 1'b0});
        for (int i = 0; i < 4 * (WIDTH + 2) + 5; i++) begin
            @(negedge clk);
            if (done_cyc.size() >= n0 + 3) break;
        end
        start = 1'b0;
        check("held_done_count", 32'(done_cyc.size() - n0), 32'd3);
        if (done_cyc.size() >= n0 + 3) begin
            check("held_spacing_1", 32'(done_cyc[n0+1] - done_cyc[n0]), 32'(WIDTH + 2));
            check("held_spacing_2", 32'(done_cyc[n0+2] - done_cyc[n0+1]), 32'(WIDTH + 2));
        end
        repeat (WIDTH + 4) @(negedge clk);
        check("held_no_extra_done", 32'(done_cyc.size() - n0), 32'd3);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
